// File: rtl/pasta_pkg.sv
// pasta_pkg: shared constants, types and helpers for the PASTA datapath blocks.
//   BITLEN     lane width in bits
//   Q          field modulus (65537)
//   PASTA_S    lanes per beat
//   clog2_min1 bits needed to encode n ids, never less than 1
//   modadd_arb_state_t  arbiter lock state
package pasta_pkg;

    localparam int unsigned BITLEN  = 17;
    localparam int unsigned Q       = 65537;
    localparam int unsigned PASTA_S = 32;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic {IDLE, BURST} modadd_arb_state_t;

endpackage

// File: rtl/modadd_rr_pick.sv
// modadd_rr_pick: combinational round-robin picker.
//   req     in   NREQ  request vector
//   rr_ptr  in   IDW   highest-priority index (must be < NREQ)
//   grant   out  NREQ  one-hot grant, all zero when no request
//   id      out  IDW   encoded index of the granted request
module modadd_rr_pick
    import pasta_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    logic [IDW:0] idx;
    logic         found;

    always_comb begin
        grant = '0;
        id    = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!found && req[idx[IDW-1:0]]) begin
                found                = 1'b1;
                grant[idx[IDW-1:0]]  = 1'b1;
                id                   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/modadd_arbiter.sv
// modadd_arbiter: shares one pipelined mod-q adder array between NREQ requesters.
// Round-robin grant, one beat per cycle, bursts lock the array to their owner.
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_last     per-requester beat offer and end-of-burst marker
//   req_a/req_b            per-requester operands, requester i in slice i
//   req_ready              one-hot accept strobe
//   ma_in1/ma_in2/ma_out   adder array operands and sum
//   resp_valid/resp_last   one-hot owner of the sum on resp_data, last-beat flag
//   resp_data              sum broadcast to all requesters
//   busy                   burst locked or any beat in flight
module modadd_arbiter
    import pasta_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LAT     = 1,
    parameter int unsigned BITLEN  = pasta_pkg::BITLEN,
    parameter int unsigned PASTA_S = pasta_pkg::PASTA_S
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0]                req_last,
    input  logic [NREQ*BITLEN*PASTA_S-1:0] req_a,
    input  logic [NREQ*BITLEN*PASTA_S-1:0] req_b,
    output logic [NREQ-1:0]                req_ready,
    output logic [BITLEN*PASTA_S-1:0]      ma_in1,
    output logic [BITLEN*PASTA_S-1:0]      ma_in2,
    input  logic [BITLEN*PASTA_S-1:0]      ma_out,
    output logic [NREQ-1:0]                resp_valid,
    output logic                           resp_last,
    output logic [BITLEN*PASTA_S-1:0]      resp_data,
    output logic                           busy
);

    localparam int unsigned W   = BITLEN * PASTA_S;
    localparam int unsigned IDW = clog2_min1(NREQ);

    modadd_arb_state_t state, state_nxt;
    logic [IDW-1:0]    rr_ptr, rr_nxt;
    logic [IDW-1:0]    owner, owner_nxt;
    logic [IDW-1:0]    gnt_id;
    logic [NREQ-1:0]   pick_grant;
    logic [IDW-1:0]    pick_id;
    logic              fire;
    logic              any_v;

    logic              v_q    [LAT];
    logic [IDW-1:0]    id_q   [LAT];
    logic              last_q [LAT];

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ-1)) ? '0 : i + IDW'(1);
    endfunction

    modadd_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .id     (pick_id)
    );

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        req_ready = '0;
        gnt_id    = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    req_ready = pick_grant;
                    gnt_id    = pick_id;
                    if (|pick_grant) begin
                        if (req_last[pick_id]) begin
                            rr_nxt = next_id(pick_id);
                        end else begin
                            state_nxt = BURST;
                            owner_nxt = pick_id;
                        end
                    end
                end
                BURST: begin
                    gnt_id = owner;
                    if (req_valid[owner]) begin
                        req_ready[owner] = 1'b1;
                        if (req_last[owner]) begin
                            state_nxt = IDLE;
                            rr_nxt    = next_id(owner);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign fire = |req_ready;

    always_comb begin
        ma_in1 = '0;
        ma_in2 = '0;
        if (fire) begin
            ma_in1 = req_a[32'(gnt_id) * W +: W];
            ma_in2 = req_b[32'(gnt_id) * W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            owner  <= owner_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                v_q[k]    <= 1'b0;
                id_q[k]   <= '0;
                last_q[k] <= 1'b0;
            end
        end else begin
            v_q[0]    <= fire;
            id_q[0]   <= gnt_id;
            last_q[0] <= fire & req_last[gnt_id];
            for (int unsigned k = 1; k < LAT; k++) begin
                v_q[k]    <= v_q[k-1];
                id_q[k]   <= id_q[k-1];
                last_q[k] <= last_q[k-1];
            end
        end
    end

    // Gated by rst_n so a beat sitting in the last stage during reset is
    // discarded rather than reported.
    always_comb begin
        resp_valid = '0;
        resp_last  = 1'b0;
        if (rst_n && v_q[LAT-1]) begin
            resp_valid[id_q[LAT-1]] = 1'b1;
            resp_last               = last_q[LAT-1];
        end
    end

    always_comb begin
        any_v = 1'b0;
        for (int unsigned k = 0; k < LAT; k++) any_v = any_v | v_q[k];
    end

    assign busy      = (state == BURST) | any_v;
    assign resp_data = ma_out;

endmodule

// File: tb/tb_modadd_arbiter.sv
module tb_modadd_arbiter;

    localparam int NR = 3;
    localparam int BL = 17;
    localparam int S  = 32;
    localparam int W  = BL * S;
    localparam int QM = 65537;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*W-1:0]  req_a;
    logic [NR*W-1:0]  req_b;
    logic [NR-1:0]    req_ready;
    logic [W-1:0]     ma_in1;
    logic [W-1:0]     ma_in2;
    logic [W-1:0]     ma_out;
    logic [NR-1:0]    resp_valid;
    logic             resp_last;
    logic [W-1:0]     resp_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    modadd_arbiter #(
        .NREQ (NR),
        .LAT  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .ma_in1     (ma_in1),
        .ma_in2     (ma_in2),
        .ma_out     (ma_out),
        .resp_valid (resp_valid),
        .resp_last  (resp_last),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One-cycle mod-q adder array
    always_ff @(posedge clk) begin
        for (int l = 0; l < S; l++) begin
            ma_out[l*BL +: BL] <= BL'((32'(ma_in1[l*BL +: BL]) + 32'(ma_in2[l*BL +: BL])) % QM);
        end
    end

    task automatic check(input string tag, input logic [599:0] obs, input logic [599:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lane(input int r, input int l, input logic [BL-1:0] a, input logic [BL-1:0] b);
        req_a[r*W + l*BL +: BL] = a;
        req_b[r*W + l*BL +: BL] = b;
    endtask

    function automatic logic [BL-1:0] lane(input int l);
        return resp_data[l*BL +: BL];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic gen(input int r);
        req_valid[r] = ($urandom_range(0, 3) != 0);
        req_last[r]  = ($urandom_range(0, 2) == 0);
        for (int l = 0; l < S; l++)
            set_lane(r, l, BL'($urandom_range(0, QM-1)), BL'($urandom_range(0, QM-1)));
    endtask

    logic [W-1:0]   exp_vec;
    logic [599:0]   exp_resp;
    logic           exp_has;
    logic [NR-1:0]  fired;
    logic [17:0]    t;
    int             beats;
    int             cycles;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset behaviour
        tick();
        req_valid = 3'b111;
        req_last  = 3'b111;
        settle();
        check("rst_ready", req_ready, 0);
        tick();
        req_valid = '0;
        settle();
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_last", resp_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ma_in1", ma_in1, 0);
        rst_n = 1'b1;

        // 1: single beat from req0, wrap at q
        set_lane(0, 0, 17'd65536, 17'd1);
        set_lane(0, 31, 17'd100, 17'd200);
        req_valid = 3'b001;
        req_last  = 3'b001;
        settle();
        check("t1_ready", req_ready, 3'b001);
        check("t1_ma_in1_l0", ma_in1[16:0], 65536);
        check("t1_ma_in2_l31", ma_in2[31*BL +: BL], 200);
        tick();
        req_valid = '0;
        settle();
        check("t1_resp_valid", resp_valid, 3'b001);
        check("t1_lane0", lane(0), 0);
        check("t1_lane31", lane(31), 300);
        check("t1_resp_last", resp_last, 1);
        tick();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_rv", resp_valid, 0);

        // 3: req1 burst of 3 with a bubble, req0 waiting (rr_ptr is 1)
        req_a = '0;
        req_b = '0;
        set_lane(1, 5, 17'd10, 17'd20);
        set_lane(0, 0, 17'd7, 17'd7);
        req_valid = 3'b011;
        req_last  = 3'b001;
        settle();
        check("t3_b1_ready", req_ready, 3'b010);
        tick();
        req_valid = 3'b001;
        settle();
        check("t3_bubble_ready", req_ready, 0);
        check("t3_bubble_busy", busy, 1);
        check("t3_b1_resp", resp_valid, 3'b010);
        check("t3_b1_lane5", lane(5), 30);
        tick();
        set_lane(1, 5, 17'd65000, 17'd600);
        req_valid = 3'b011;
        settle();
        check("t3_b2_ready", req_ready, 3'b010);
        tick();
        set_lane(1, 5, 17'd3, 17'd4);
        req_last = 3'b011;
        settle();
        check("t3_b3_ready", req_ready, 3'b010);
        check("t3_b2_resp", resp_valid, 3'b010);
        check("t3_b2_lane5", lane(5), 63);
        check("t3_b2_last", resp_last, 0);
        tick();
        req_valid = 3'b001;
        settle();
        check("t3_req0_ready", req_ready, 3'b001);
        check("t3_b3_resp", resp_valid, 3'b010);
        check("t3_b3_last", resp_last, 1);
        check("t3_b3_lane5", lane(5), 7);
        tick();
        req_valid = '0;
        settle();
        check("t3_req0_resp", resp_valid, 3'b001);
        check("t3_req0_lane0", lane(0), 14);
        tick();

        // 2: simultaneous single beats from rr_ptr=0
        do_reset();
        req_a = '0;
        req_b = '0;
        set_lane(0, 1, 17'd1, 17'd2);
        set_lane(1, 1, 17'd5, 17'd6);
        req_valid = 3'b011;
        req_last  = 3'b011;
        settle();
        check("t2_first", req_ready, 3'b001);
        tick();
        req_valid = 3'b010;
        settle();
        check("t2_second", req_ready, 3'b010);
        check("t2_resp0", resp_valid, 3'b001);
        check("t2_resp0_lane1", lane(1), 3);
        tick();
        req_valid = '0;
        settle();
        check("t2_resp1", resp_valid, 3'b010);
        check("t2_resp1_lane1", lane(1), 11);
        check("t2_busy_tail", busy, 1);
        tick();
        check("t2_busy_drop", busy, 0);

        // 6: quiet period
        for (int i = 0; i < 10; i++) begin
            check("t6_ma_in1", ma_in1, 0);
            check("t6_ma_in2", ma_in2, 0);
            check("t6_resp_valid", resp_valid, 0);
            check("t6_busy", busy, 0);
            check("t6_ready", req_ready, 0);
            tick();
        end

        // 5: reset mid-burst with a beat in flight (rr_ptr is 2 beforehand)
        req_a = '0;
        req_b = '0;
        set_lane(0, 2, 17'd40, 17'd2);
        req_valid = 3'b001;
        req_last  = 3'b000;
        settle();
        check("t5_b1_ready", req_ready, 3'b001);
        tick();
        set_lane(0, 2, 17'd50, 17'd3);
        settle();
        check("t5_b2_ready", req_ready, 3'b001);
        check("t5_b1_resp", resp_valid, 3'b001);
        tick();
        rst_n = 1'b0;
        settle();
        check("t5_rst_resp", resp_valid, 0);
        check("t5_rst_ready", req_ready, 0);
        tick();
        rst_n     = 1'b1;
        req_a     = '0;
        req_b     = '0;
        set_lane(1, 2, 17'd8, 17'd9);
        req_valid = 3'b110;
        req_last  = 3'b110;
        settle();
        check("t5_post_resp", resp_valid, 0);
        check("t5_post_busy", busy, 0);
        check("t5_post_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        settle();
        check("t5_post_resp1", resp_valid, 3'b010);
        check("t5_post_lane2", lane(2), 17);
        tick();

        // 4: max operands on every lane
        for (int l = 0; l < S; l++) begin
            set_lane(2, l, 17'd65536, 17'd65536);
            exp_vec[l*BL +: BL] = 17'd65535;
        end
        req_valid = 3'b100;
        req_last  = 3'b100;
        settle();
        check("t4_max_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        settle();
        check("t4_max_rv", resp_valid, 3'b100);
        check("t4_max_data", resp_data, exp_vec);
        tick();

        // 4: random traffic with scoreboard
        exp_has = 1'b0;
        exp_resp = '0;
        beats   = 0;
        cycles  = 0;
        for (int r = 0; r < NR; r++) gen(r);
        while (beats < 1000 && cycles < 6000) begin
            settle();
            if (exp_has)
                check("rnd_resp", {resp_valid, resp_last, resp_data}, exp_resp);
            else
                check("rnd_idle", resp_valid, 0);
            check("rnd_onehot", $onehot0(req_ready), 1);
            exp_has = 1'b0;
            for (int r = 0; r < NR; r++) begin
                if (req_ready[r]) begin
                    for (int l = 0; l < S; l++) begin
                        t = 18'(req_a[r*W + l*BL +: BL]) + 18'(req_b[r*W + l*BL +: BL]);
                        exp_vec[l*BL +: BL] = (t >= 18'(QM)) ? BL'(t - 18'(QM)) : BL'(t);
                    end
                    exp_resp = {(NR'(1) << r), req_last[r], exp_vec};
                    exp_has  = 1'b1;
                    beats++;
                end
            end
            fired = req_ready;
            tick();
            cycles++;
            for (int r = 0; r < NR; r++) begin
                if (fired[r] || !req_valid[r]) gen(r);
            end
        end
        check("rnd_budget", beats >= 1000, 1);
        req_valid = '0;
        settle();
        if (exp_has)
            check("rnd_drain", {resp_valid, resp_last, resp_data}, exp_resp);
        tick();
        check("rnd_drain_idle", resp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
